// File: rtl/hysteresis_saturating_counter.sv
// Saturating up/down counter with a hysteresis jump across the midpoint; 1-cycle latency,
// count is a plain register. No backpressure: a request is applied or held on every edge.
module hysteresis_saturating_counter #(
    parameter int RANGE       = 4,
    parameter int RESET_VALUE = 0,
    parameter int COERCIVITY  = 1
) (
    input  logic                                        clock,
    input  logic                                        resetn,
    input  logic                                        increment,
    input  logic                                        decrement,
    output logic [((RANGE > 1) ? $clog2(RANGE) : 1)-1:0] count
);

    localparam int W = (RANGE > 1) ? $clog2(RANGE) : 1;

    localparam logic [W-1:0] MAX_V     = W'(RANGE - 1);
    localparam logic [W-1:0] HALF_LOW  = W'(RANGE / 2 - 1);
    localparam logic [W-1:0] HALF_HIGH = W'(RANGE / 2);
    localparam logic [W-1:0] JUMP_HIGH = W'(RANGE / 2 + COERCIVITY);
    localparam logic [W-1:0] JUMP_LOW  = W'(RANGE / 2 - 1 - COERCIVITY);
    localparam logic [W-1:0] RESET_V   = W'(RESET_VALUE);

    if (RANGE < 2 || (RANGE % 2) != 0) begin : g_bad_range
        $error("hysteresis_saturating_counter: RANGE must be even and >= 2");
    end
    if (COERCIVITY < 0 || COERCIVITY > RANGE / 2 - 1) begin : g_bad_coercivity
        $error("hysteresis_saturating_counter: COERCIVITY must be in 0..RANGE/2-1");
    end
    if (RESET_VALUE < 0 || RESET_VALUE > RANGE - 1) begin : g_bad_reset_value
        $error("hysteresis_saturating_counter: RESET_VALUE must be in 0..RANGE-1");
    end

    logic step_up;
    logic step_down;

    // Opposing requests cancel; saturation suppresses the step instead of wrapping.
    assign step_up   = increment && !decrement && (count != MAX_V);
    assign step_down = decrement && !increment && (count != '0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= RESET_V;
        end else if (step_up) begin
            count <= (count == HALF_LOW) ? JUMP_HIGH : count + 1'b1;
        end else if (step_down) begin
            count <= (count == HALF_HIGH) ? JUMP_LOW : count - 1'b1;
        end
    end

endmodule

// File: tb/tb_hysteresis_saturating_counter.sv
// Bench for hysteresis_saturating_counter: two instances (4 states/coercivity 1 and
// 8 states/coercivity 2) checked every cycle against an arithmetic model plus literal points.
module tb_hysteresis_saturating_counter;

    logic       clock;
    logic       resetn;
    logic       inc4, dec4, inc8, dec8;
    logic [1:0] count4;
    logic [2:0] count8;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int exp4   = 0;
    int exp8   = 0;

    hysteresis_saturating_counter #(.RANGE(4), .RESET_VALUE(0), .COERCIVITY(1)) u_dut4 (
        .clock(clock), .resetn(resetn), .increment(inc4), .decrement(dec4), .count(count4)
    );

    hysteresis_saturating_counter #(.RANGE(8), .RESET_VALUE(0), .COERCIVITY(2)) u_dut8 (
        .clock(clock), .resetn(resetn), .increment(inc8), .decrement(dec8), .count(count8)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Stepping up onto the upper half lands coer extra steps further; stepping down
    // off the bottom of the upper half lands coer extra steps lower.
    function automatic int model_next(int c, bit i, bit d, int range, int coer);
        if (i && !d && c < range - 1)
            return (c + 1 == range / 2) ? c + 1 + coer : c + 1;
        if (d && !i && c > 0)
            return (c == range / 2) ? c - 1 - coer : c - 1;
        return c;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            exp4 <= 0;
            exp8 <= 0;
        end else begin
            exp4 <= model_next(exp4, inc4, dec4, 4, 2 - 1);
            exp8 <= model_next(exp8, inc8, dec8, 8, 2);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            checks++;
            if ({30'd0, count4} !== exp4[31:0]) begin
                errors++;
                $display("FAIL model4 t=%0t count=%0d expected=%0d", $time, count4, exp4);
            end
            checks++;
            if ({29'd0, count8} !== exp8[31:0]) begin
                errors++;
                $display("FAIL model8 t=%0t count=%0d expected=%0d", $time, count8, exp8);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, want);
        end
    endtask

    task automatic step(input bit i4, input bit d4, input bit i8, input bit d8);
        @(negedge clock);
        inc4 = i4; dec4 = d4; inc8 = i8; dec8 = d8;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b1;
        inc4 = 0; dec4 = 0; inc8 = 0; dec8 = 0;
        #1 resetn = 1'b0;
        #2;
        check("reset4", {30'd0, count4}, 0);
        check("reset8", {29'd0, count8}, 0);
        @(negedge clock);
        chk_en = 1'b1;
        resetn = 1'b1;

        step(0, 0, 0, 0);
        check("idle4", {30'd0, count4}, 0);
        step(1, 0, 1, 0);
        check("inc4_to_half_low", {30'd0, count4}, 1);
        check("model4_half_low", exp4, 1);
        step(1, 0, 1, 0);
        check("inc4_jump_high", {30'd0, count4}, 3);
        check("model4_jump_high", exp4, 3);
        step(1, 0, 1, 0);
        check("inc4_saturate", {30'd0, count4}, 3);
        check("inc8_to_half_low", {29'd0, count8}, 3);
        step(0, 1, 1, 0);
        check("dec4_to_half_high", {30'd0, count4}, 2);
        check("inc8_jump_high", {29'd0, count8}, 6);
        check("model8_jump_high", exp8, 6);
        step(0, 1, 1, 0);
        check("dec4_jump_low", {30'd0, count4}, 0);
        check("model4_jump_low", exp4, 0);
        check("inc8_to_top", {29'd0, count8}, 7);
        step(0, 1, 0, 1);
        check("dec4_saturate", {30'd0, count4}, 0);
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        check("both4_a", {30'd0, count4}, 1);
        check("dec8_to_half_high", {29'd0, count8}, 4);
        step(1, 1, 0, 1);
        check("both4_b", {30'd0, count4}, 1);
        check("dec8_jump_low", {29'd0, count8}, 1);
        check("model8_jump_low", exp8, 1);
        step(1, 1, 1, 1);
        check("both4_c", {30'd0, count4}, 1);
        step(0, 0, 0, 0);
        check("idle4_hold", {30'd0, count4}, 1);

        // Asynchronous reset asserted mid-cycle while an increment is pending.
        @(negedge clock);
        inc4 = 1; inc8 = 1;
        #2 resetn = 1'b0;
        #1;
        check("async_reset4", {30'd0, count4}, 0);
        check("async_reset8", {29'd0, count8}, 0);
        @(posedge clock);
        #1;
        check("reset_hold4", {30'd0, count4}, 0);
        @(negedge clock);
        resetn = 1'b1;
        inc4 = 0; inc8 = 0;

        for (int n = 0; n < 100; n++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        // Biased runs so both counters spend time at the rails and in the hysteresis band.
        for (int n = 0; n < 60; n++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hysteresis_saturating_counter.md
Name: hysteresis_saturating_counter

Overview:
Saturating up/down counter over [0, RANGE-1] with a hysteresis band around the midpoint. Crossing the midpoint jumps past it by COERCIVITY extra steps, so a single opposite step cannot cross straight back. Typical use is a branch-predictor or confidence counter, where the upper half means "taken" or "confident". The output is a registered count consumed by the surrounding predictor or arbitration logic.

Parameters:
RANGE, 4, number of count states. Must be even and >= 2. count spans 0..RANGE-1.
RESET_VALUE, 0, value loaded on reset. Must be in 0..RANGE-1.
COERCIVITY, 1, extra steps skipped when crossing the midpoint. Must be in 0..RANGE/2-1. 0 gives a plain saturating counter.

Ports:
clock  input  1  single clock; all state changes on the rising edge.
resetn  input  1  asynchronous, active-low reset.
increment  input  1  request +1 step this cycle.
decrement  input  1  request -1 step this cycle.
count  output  $clog2(RANGE) (min 1)  current counter value, driven directly from a register.

Behaviour:
- Derived constants:
  - HALF_LOW = RANGE/2-1
  - HALF_HIGH = RANGE/2
  - JUMP_HIGH = HALF_HIGH+COERCIVITY
  - JUMP_LOW = HALF_LOW-COERCIVITY
- Reset: resetn low asynchronously forces count = RESET_VALUE. The value holds while resetn is low. Counting resumes on the first rising edge after deassertion.
- On each rising edge with resetn high, the next count is chosen by the first matching rule:
  - increment=1, decrement=0, count != RANGE-1: if count == HALF_LOW then JUMP_HIGH, else count+1.
  - decrement=1, increment=0, count != 0: if count == HALF_HIGH then JUMP_LOW, else count-1.
  - otherwise (neither asserted, both asserted, or saturated in the requested direction): hold.
- Latency: one cycle. The new value is visible on count after the rising edge that samples the request.
- Saturation:
  - Increment at RANGE-1 holds at RANGE-1.
  - Decrement at 0 holds at 0.
  - No wrap-around.
- Simultaneous increment and decrement: hold. Inputs cancel; no net step.
- Hysteresis is asymmetric by state, not by history:
  - Values strictly between HALF_HIGH and JUMP_HIGH are reachable only by decrementing from above.
  - Likewise for values between JUMP_LOW and HALF_LOW, which are reachable only by incrementing from below.
  - All values 0..RANGE-1 remain legal and step normally.
- The jump targets always lie in range given the parameter constraints. No extra clamping is needed.
- Reset mid-operation overrides any pending increment or decrement immediately.
- Parameter violations (odd RANGE, COERCIVITY out of range, RESET_VALUE out of range) are flagged by elaboration-time assertions.

Test Plan:
1. Reset (RANGE=4, RESET_VALUE=0, COERCIVITY=1): pulse resetn low, then release -> count=0, stays 0 with no requests.
2. Increment below midpoint: from 0, hold increment=1 -> count goes 0→1 after one edge (HALF_LOW=1 reached).
3. Jump up and saturate:
   - From 1, one increment -> count=3 (JUMP_HIGH), skipping 2.
   - Further increments -> stays 3.
4. Decrement path:
   - From 3, decrement -> 2 (HALF_HIGH).
   - Next decrement -> 0 (JUMP_LOW), skipping 1.
   - Further decrements -> stays 0.
5. Simultaneous and idle:
   - At count=1, assert increment and decrement together for 3 cycles -> count stays 1.
   - Deassert both -> stays 1.
   - Assert resetn low mid-increment -> count=0 immediately.
6. Random: 100 cycles, increment and decrement each driven with probability 0.5. After each edge, count must equal the prediction model from the Behaviour rules, including saturation and cancellation. Also repeat with RANGE=8, COERCIVITY=2: from 3, increment -> 6; from 4, decrement -> 1.
